// File: rtl/screen_scanout.sv
// screen_scanout: streams the CHIP-8 64x32 1-bpp framebuffer out as x/y-tagged pixels.
// Define SCANOUT_PREFETCH_EN to add a one-byte read-ahead buffer for a bubble-free stream.
module screen_scanout #(
  parameter logic [15:0] SCREEN_START = 16'h0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        ready,
  output logic        frame_done,
  input  logic        mem_busy,
  output logic        mem_read,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_read_byte,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_data,
  output logic [5:0]  pix_x,
  output logic [4:0]  pix_y
);

  typedef enum logic [1:0] {StIdle, StReq, StLoad, StShift} state_e;

  state_e      state_q, state_d;
  logic [7:0]  index_q, index_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        mem_read_q, mem_read_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        pix_valid_q, pix_valid_d;
  logic        frame_done_q, frame_done_d;
  logic        handshake;
`ifdef SCANOUT_PREFETCH_EN
  logic [7:0]  pbuf_q, pbuf_d;
  logic        pbuf_valid_q, pbuf_valid_d;
  logic        pf_pend_q, pf_pend_d;
`endif

  assign handshake = pix_valid_q & pix_ready;

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    mem_read_d   = 1'b0;
    mem_addr_d   = mem_addr_q;
    pix_valid_d  = pix_valid_q;
    frame_done_d = 1'b0;
`ifdef SCANOUT_PREFETCH_EN
    pbuf_d       = pbuf_q;
    pbuf_valid_d = pbuf_valid_q;
    pf_pend_d    = pf_pend_q;
`endif
    unique case (state_q)
      StIdle: begin
        // ready is held low during the frame_done cycle, so start is ignored there too
        if (start && !frame_done_q) begin
          index_d = 8'd0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (!mem_busy) begin
          mem_read_d = 1'b1;
          mem_addr_d = SCREEN_START + {8'h00, index_q};
          state_d    = StLoad;
        end
      end
      StLoad: begin
        shreg_d     = mem_read_byte;
        bit_cnt_d   = 3'd0;
        pix_valid_d = 1'b1;
        state_d     = StShift;
      end
      StShift: begin
`ifdef SCANOUT_PREFETCH_EN
        if (pf_pend_q) begin
          pbuf_d       = mem_read_byte;
          pbuf_valid_d = 1'b1;
          pf_pend_d    = 1'b0;
        end else if (!pbuf_valid_q && index_q != 8'hff && !mem_busy) begin
          mem_read_d = 1'b1;
          mem_addr_d = SCREEN_START + {8'h00, index_q + 8'd1};
          pf_pend_d  = 1'b1;
        end
`endif
        if (handshake) begin
          shreg_d   = {shreg_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (index_q == 8'hff) begin
              pix_valid_d  = 1'b0;
              frame_done_d = 1'b1;
              state_d      = StIdle;
            end else begin
              index_d = index_q + 8'd1;
`ifdef SCANOUT_PREFETCH_EN
              if (pbuf_valid_q) begin
                shreg_d      = pbuf_q;
                pbuf_valid_d = 1'b0;
              end else begin
                // Prefetch not ready in time: drop any in-flight read and refetch normally
                pix_valid_d  = 1'b0;
                pbuf_valid_d = 1'b0;
                pf_pend_d    = 1'b0;
                mem_read_d   = 1'b0;
                state_d      = StReq;
              end
`else
              pix_valid_d = 1'b0;
              state_d     = StReq;
`endif
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      index_q      <= 8'd0;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 8'd0;
      mem_read_q   <= 1'b0;
      mem_addr_q   <= 16'd0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SCANOUT_PREFETCH_EN
      pbuf_q       <= 8'd0;
      pbuf_valid_q <= 1'b0;
      pf_pend_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      mem_read_q   <= mem_read_d;
      mem_addr_q   <= mem_addr_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
`ifdef SCANOUT_PREFETCH_EN
      pbuf_q       <= pbuf_d;
      pbuf_valid_q <= pbuf_valid_d;
      pf_pend_q    <= pf_pend_d;
`endif
    end
  end

  assign ready      = (state_q == StIdle) && !frame_done_q;
  assign frame_done = frame_done_q;
  assign mem_read   = mem_read_q;
  assign mem_addr   = mem_addr_q;
  assign pix_valid  = pix_valid_q;
  assign pix_data   = shreg_q[7];
  assign pix_x      = {index_q[2:0], bit_cnt_q};
  assign pix_y      = index_q[7:3];

endmodule

// File: tb/tb_screen_scanout.sv
// Bench for screen_scanout: random stalls/busy against a coordinate-level framebuffer model.
module tb_screen_scanout;

`ifdef SCANOUT_PREFETCH_EN
  localparam int SPAN = 2047;
  localparam int ADDR_AFTER_BUSY = 32'h10A;
`else
  localparam int SPAN = 2047 + 255 * 2;
  localparam int ADDR_AFTER_BUSY = 32'h109;
`endif

  logic        clk, rst_n, start, ready, frame_done, mem_busy, mem_read;
  logic        pix_valid, pix_ready, pix_data;
  logic [15:0] mem_addr;
  logic [7:0]  mem_read_byte;
  logic [5:0]  pix_x;
  logic [4:0]  pix_y;
  logic [7:0]  mem [0:65535];

  int total, bad, cyc, st_cyc, done_cnt;
  int fpix, first_cyc, last_cyc, rd_cnt, rd_min, rd_max, rd_last;
  int s_pix, s_first, s_span, s_gap, s_rd_cnt, s_rd_min, s_rd_max, s_rd_last;
  bit rdy_rand, busy_rand, busy_force, rdy_bit, busy_bit;

  assign mem_read_byte = mem[mem_addr];
  assign pix_ready     = rdy_rand ? rdy_bit : 1'b1;
  assign mem_busy      = busy_force | busy_bit;

  screen_scanout #(.SCREEN_START(16'h0100)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .frame_done(frame_done),
    .mem_busy(mem_busy), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_read_byte(mem_read_byte), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    rdy_bit  = 1'b1;
    busy_bit = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rdy_bit  = 1'($urandom % 2);
      busy_bit = busy_rand && ($urandom % 4 == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // n-th pixel of a frame in row-major order: {x, y, lit}
  function automatic logic [11:0] exp_pix(input int n);
    int x, y;
    logic [15:0] a;
    logic [7:0]  b;
    x = n % 64;
    y = n / 64;
    a = 16'(32'h100 + y * 8 + x / 8);
    b = mem[a];
    return {x[5:0], y[4:0], b[7 - (x % 8)]};
  endfunction

  initial begin
    logic        stall;
    logic [12:0] held;
    stall = 1'b0; held = '0; fpix = 0; done_cnt = 0; first_cyc = 0; last_cyc = 0;
    rd_cnt = 0; rd_min = 32'hffff; rd_max = 0; rd_last = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0; fpix = 0; rd_cnt = 0; rd_min = 32'hffff; rd_max = 0; rd_last = 0;
      end else begin
        if (stall) check("stall_hold", {pix_valid, pix_data, pix_x, pix_y}, held);
        if (pix_valid && pix_ready) begin
          check("pixel", {pix_x, pix_y, pix_data}, exp_pix(fpix));
          if (fpix == 0) first_cyc = cyc;
          last_cyc = cyc;
          fpix++;
        end
        stall = pix_valid && !pix_ready;
        held  = {pix_valid, pix_data, pix_x, pix_y};
        if (mem_read) begin
          rd_cnt++;
          if (int'(mem_addr) < rd_min) rd_min = int'(mem_addr);
          if (int'(mem_addr) > rd_max) rd_max = int'(mem_addr);
          rd_last = int'(mem_addr);
        end
        if (frame_done) begin
          done_cnt++;
          s_pix = fpix; s_first = first_cyc; s_span = last_cyc - first_cyc;
          s_gap = cyc - last_cyc; s_rd_cnt = rd_cnt; s_rd_min = rd_min;
          s_rd_max = rd_max; s_rd_last = rd_last;
          fpix = 0; rd_cnt = 0; rd_min = 32'hffff; rd_max = 0;
        end
      end
    end
  end

  task automatic start_frame();
    @(posedge clk);
    #1 start = 1'b1;
    st_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic finish_frame(input bit chk_time, input bit chk_reads);
    int  d0;
    bit  seen;
    d0   = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_done_seen", 32'(seen), 1);
    if (!seen) return;
    check("ready_low_at_done", 32'(ready), 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("start_at_done_ignored", {ready, pix_valid}, 2'b10);
    repeat (3) @(negedge clk);
    check("no_rescan", 32'(mem_read), 0);
    check("done_once", done_cnt - d0, 1);
    check("pixel_count", s_pix, 2048);
    check("done_gap", s_gap, 1);
    check("rd_min", s_rd_min, 32'h100);
    check("rd_max", s_rd_max, 32'h1FF);
    check("rd_last", s_rd_last, 32'h1FF);
    if (chk_time) begin
      check("latency", s_first - st_cyc, 3);
      check("span", s_span, SPAN);
    end
    if (chk_reads) check("rd_count", s_rd_cnt, 256);
  endtask

  task automatic wait_pix(input int x, input int y);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (pix_valid && pix_ready && int'(pix_x) == x && int'(pix_y) == y) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_pixel", 32'(ok), 1);
  endtask

  initial begin
    int d0;
    total = 0; bad = 0;
    start = 1'b0; rdy_rand = 1'b0; busy_rand = 1'b0; busy_force = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(ready), 1);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_mem_read", 32'(mem_read), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_pix_fields", {pix_data, pix_x, pix_y}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Corner pixels of the first byte
    mem[16'h100] = 8'h81;
    start_frame();
    finish_frame(1'b1, 1'b1);

    // Only the very last pixel lit
    mem[16'h100] = 8'h00;
    mem[16'h1FF] = 8'h01;
    start_frame();
    finish_frame(1'b1, 1'b1);

    // Random image with downstream stalls, then with GPU contention as well
    for (int i = 16'h100; i < 16'h200; i++) mem[i] = 8'($urandom);
    rdy_rand = 1'b1;
    start_frame();
    finish_frame(1'b0, 1'b1);
    busy_rand = 1'b1;
    start_frame();
    finish_frame(1'b0, 1'b0);
    rdy_rand = 1'b0;
    busy_rand = 1'b0;

    // Memory held busy across the fetch of byte 9
    start_frame();
    wait_pix(7, 1);
    busy_force = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check("busy_no_read", 32'(mem_read), 0);
    end
    busy_force = 1'b0;
    @(negedge clk);
    check("read_after_busy", {mem_read, mem_addr}, {1'b1, 16'(ADDR_AFTER_BUSY)});
    finish_frame(1'b0, 1'b1);

    // Reset mid-frame at byte 40
    start_frame();
    wait_pix(0, 5);
    d0 = done_cnt;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ready_valid", {ready, pix_valid, mem_read, frame_done}, 4'b1000);
    check("midrst_xy", {pix_x, pix_y}, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_idle", {ready, pix_valid}, 2'b10);
    start_frame();
    finish_frame(1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
